// File: rtl/counter_load_ctrl.sv
// counter_load_ctrl: sequencer for a loadable up-counter. It accepts presets from a host,
// loads the counter, and on terminal count either stops (one-shot) or reloads (auto-reload).
// It also keeps a saturating tally of completed periods.
module counter_load_ctrl #(
  parameter int unsigned         WIDTH    = 4,
  parameter logic [WIDTH-1:0]    TERMINAL = {WIDTH{1'b1}},
  parameter int unsigned         WRAP_W   = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [WIDTH-1:0]  Preset,
  input  logic              PresetValid,
  output logic              PresetReady,
  input  logic              AutoReload,
  input  logic              Abort,
  input  logic [WIDTH-1:0]  CountIn,
  output logic [WIDTH-1:0]  DataIn,
  output logic              Load,
  output logic              Busy,
  output logic              Done,
  output logic [WRAP_W-1:0] WrapCount
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   shadow;
  logic [WIDTH-1:0]   pend;
  logic               pend_valid;
  logic               mode;
  logic               done;
  logic [WRAP_W-1:0]  wrap;
  logic               term;
  logic               accept;

  assign term   = (state == RUN) && (CountIn == TERMINAL);
  assign accept = PresetValid && PresetReady;

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state, handshake ready and counter load strobe
  always_comb begin
    state_next  = state;
    PresetReady = 1'b0;
    Load        = 1'b0;
    case (state)
      IDLE: begin
        PresetReady = ~Rst;
        if (accept) state_next = LOAD;
      end
      LOAD: begin
        Load       = ~Abort & ~Rst;
        state_next = Abort ? IDLE : RUN;
      end
      RUN: begin
        PresetReady = ~pend_valid & ~Abort & ~Rst;
        Load        = term & mode & ~Abort & ~Rst;
        if (Abort)             state_next = IDLE;
        else if (term && !mode) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Shadow/pending presets, mode, period tally and done pulse
  always_ff @(posedge Clk) begin
    if (Rst) begin
      shadow     <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      mode       <= 1'b0;
      done       <= 1'b0;
      wrap       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            shadow <= Preset;
            mode   <= AutoReload;
            wrap   <= '0;
          end
        end
        LOAD: begin
          if (Abort) pend_valid <= 1'b0;
        end
        RUN: begin
          if (Abort) begin
            pend_valid <= 1'b0;
          end else begin
            // A preset taken alongside a reload waits for the next terminal
            if (accept) begin
              pend       <= Preset;
              pend_valid <= 1'b1;
            end
            if (term) begin
              if (wrap != {WRAP_W{1'b1}}) wrap <= wrap + WRAP_W'(1);
              if (mode) begin
                if (pend_valid) begin
                  shadow     <= pend;
                  pend_valid <= 1'b0;
                end
              end else begin
                done       <= 1'b1;
                pend_valid <= 1'b0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign DataIn    = shadow;
  assign Busy      = (state != IDLE);
  assign Done      = done;
  assign WrapCount = wrap;

endmodule

// File: tb/tb_counter_load_ctrl.sv
// Bench for counter_load_ctrl wired to a behavioural 4-bit loadable up-counter.
module tb_counter_load_ctrl;

  typedef struct packed {
    logic       ready;
    logic       load;
    logic [3:0] di;
    logic       busy;
    logic       done;
    logic [7:0] wc;
    logic [3:0] cnt;
  } outs_t;

  typedef struct {
    string      name;
    logic       rst;
    logic       pv;
    logic [3:0] preset;
    logic       auto;
    logic       abort;
    outs_t      exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] preset = '0;
  logic       pv = 1'b0;
  logic       ready;
  logic       auto_r = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] cnt;
  logic [3:0] data_in;
  logic       load;
  logic       busy;
  logic       done;
  logic [7:0] wc;

  int checks = 0;
  int errors = 0;
  outs_t exp_q[$];
  vec_t  tbl[$];

  always #5 clk = ~clk;

  counter_load_ctrl dut (
    .Clk(clk), .Rst(rst), .Preset(preset), .PresetValid(pv), .PresetReady(ready),
    .AutoReload(auto_r), .Abort(abort), .CountIn(cnt), .DataIn(data_in), .Load(load),
    .Busy(busy), .Done(done), .WrapCount(wc)
  );

  // Counter being sequenced: loads DataIn on Load, otherwise counts up and wraps
  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (load) cnt <= data_in;
    else           cnt <= cnt + 4'd1;
  end

  function automatic outs_t mk(input logic r, input logic l, input int d, input logic b,
                               input logic dn, input int w, input int c);
    outs_t o;
    o.ready = r; o.load = l; o.di = 4'(d); o.busy = b; o.done = dn; o.wc = 8'(w); o.cnt = 4'(c);
    return o;
  endfunction

  function automatic void add(input string n, input logic r, input logic v, input int p,
                              input logic a, input logic ab, input outs_t e);
    vec_t t;
    t.name = n; t.rst = r; t.pv = v; t.preset = 4'(p); t.auto = a; t.abort = ab; t.exp = e;
    tbl.push_back(t);
  endfunction

  // One clock: drive after the edge, queue expectation, compare on the falling edge
  task automatic step(input string n, input logic r, input logic v, input int p,
                      input logic a, input logic ab, input outs_t e);
    outs_t got;
    outs_t ex;
    @(posedge clk);
    #1;
    rst = r; pv = v; preset = 4'(p); auto_r = a; abort = ab;
    exp_q.push_back(e);
    @(negedge clk);
    got = '{ready: ready, load: load, di: data_in, busy: busy, done: done, wc: wc, cnt: cnt};
    ex = exp_q.pop_front();
    checks++;
    if (got !== ex) begin
      errors++;
      $display("FAIL %s: got rdy=%b ld=%b di=%0d bsy=%b dn=%b wc=%0d cnt=%0d, want rdy=%b ld=%b di=%0d bsy=%b dn=%b wc=%0d cnt=%0d",
               n, got.ready, got.load, got.di, got.busy, got.done, got.wc, got.cnt,
               ex.ready, ex.load, ex.di, ex.busy, ex.done, ex.wc, ex.cnt);
    end
  endtask

  initial begin
    // Reset then a one-shot period from 7
    for (int i = 0; i < 3; i++) add("reset", 1, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
    add("reset_exit", 0, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0));
    add("os_accept",  0, 1, 7, 0, 0, mk(1, 0, 0, 0, 0, 0, 1));
    add("os_load",    0, 0, 0, 0, 0, mk(0, 1, 7, 1, 0, 0, 2));
    for (int c = 7; c <= 15; c++) add("os_run", 0, 0, 0, 0, 0, mk(1, 0, 7, 1, 0, 0, c));
    add("os_done",    0, 0, 0, 0, 0, mk(1, 0, 7, 0, 1, 1, 0));
    add("os_after",   0, 0, 0, 0, 0, mk(1, 0, 7, 0, 0, 1, 1));

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].name, tbl[i].rst, tbl[i].pv, int'(tbl[i].preset), tbl[i].auto, tbl[i].abort, tbl[i].exp);

    // Auto-reload from 12 for three periods
    step("auto_accept", 0, 1, 12, 1, 0, mk(1, 0, 7, 0, 0, 1, 2));
    step("auto_load",   0, 0, 0, 0, 0, mk(0, 1, 12, 1, 0, 0, 3));
    for (int p = 0; p < 3; p++)
      for (int k = 0; k < 4; k++)
        step("auto_run", 0, 0, 0, 0, 0, mk(1, k == 3, 12, 1, 0, p, 12 + k));

    // Offer 10 mid-period: held pending, current period completes at 12
    step("pend_offer", 0, 1, 10, 0, 0, mk(1, 0, 12, 1, 0, 3, 12));
    for (int k = 1; k < 4; k++)
      step("pend_full", 0, 0, 0, 0, 0, mk(0, k == 3, 12, 1, 0, 3, 12 + k));
    for (int k = 0; k < 4; k++)
      step("pend_swap", 0, 0, 0, 0, 0, mk(1, k == 3, 10, 1, 0, 4, 12 + k));
    for (int k = 0; k < 6; k++)
      step("run_from10", 0, 0, 0, 0, 0, mk(1, k == 5, 10, 1, 0, 5, 10 + k));
    for (int k = 0; k < 5; k++)
      step("run_from10b", 0, 0, 0, 0, 0, mk(1, 0, 10, 1, 0, 6, 10 + k));

    // Abort on the terminal cycle, with a preset offered at the same time
    step("abort_term",  0, 1, 3, 0, 1, mk(0, 0, 10, 1, 0, 6, 15));
    step("abort_idle",  0, 0, 0, 0, 0, mk(1, 0, 10, 0, 0, 6, 0));
    step("abort_noop",  0, 0, 0, 0, 1, mk(1, 0, 10, 0, 0, 6, 1));

    // Auto preset 15: load every run cycle, tally saturates at 255
    step("acc15",       0, 1, 15, 1, 1, mk(1, 0, 10, 0, 0, 6, 2));
    step("load15",      0, 0, 0, 0, 0, mk(0, 1, 15, 1, 0, 0, 3));
    for (int i = 0; i < 300; i++)
      step("sat_run", 0, 0, 0, 0, 0, mk(1, 1, 15, 1, 0, (i < 255) ? i : 255, 15));

    // Reset mid-run
    step("rst_mid",     1, 0, 0, 0, 0, mk(0, 0, 15, 1, 0, 255, 15));
    step("rst_after",   0, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
